hub75_capture: RTL

- Receive-side counterpart of the HUB75 panel driver.
- Monitors the panel bus (panel_clk, panel_stb, panel_oe, row address, RGB0/RGB1) and rebuilds each shifted row as a pixel stream.
- Each row is tagged with row address, bit-plane index and column.
- Used for loopback checking of the driver on hardware and as the front end of a daisy-chain repeater.

---
 rtl/hub75_capture.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hub75_capture.sv
// HUB75 bus receiver: rebuilds each latched row from the panel shift bus into a
// tagged pixel stream, using ping-pong line buffers drained through a ready/valid port.
module hub75_capture #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ROW_BITS = 5,
    parameter int unsigned PLANES   = 8,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                      display_clock,
    input  logic                      display_resetn,
    input  logic                      panel_clk,
    input  logic                      panel_stb,
    input  logic                      panel_oe,
    input  logic [ROW_BITS-1:0]       panel_addr,
    input  logic [5:0]                panel_rgb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0]                out_pixel,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic [ROW_BITS-1:0]       out_row,
    output logic [$clog2(PLANES)-1:0] out_plane,
    output logic                      out_last,
    output logic                      frame_start,
    output logic [15:0]               oe_cycles,
    output logic [CNT_BITS-1:0]       lines_dropped,
    output logic [CNT_BITS-1:0]       line_errors
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = $clog2(PLANES);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state;

    logic [1:0]          clk_sync, stb_sync, oe_sync;
    logic                clk_d, stb_d;
    logic [ROW_BITS-1:0] addr_s1, addr_s2;
    logic [5:0]          rgb_s1, rgb_s2;

    logic [CW:0]         col_cnt, col_next;
    logic                overrun, overrun_next;
    logic                fill_sel;
    logic [ROW_BITS-1:0] prev_row;
    logic [PW-1:0]       plane, plane_next;
    logic [15:0]         oe_cnt;
    logic [5:0]          line_mem [2][WIDTH];

    logic clk_rise, stb_rise, fill_full, line_ok, drain_free, commit;
    logic [CW-1:0] col_inc;

    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn) begin
            clk_sync <= '0;
            stb_sync <= '0;
            oe_sync  <= '0;
            clk_d    <= 1'b0;
            stb_d    <= 1'b0;
            addr_s1  <= '0;
            addr_s2  <= '0;
            rgb_s1   <= '0;
            rgb_s2   <= '0;
        end else begin
            clk_sync <= {clk_sync[0], panel_clk};
            stb_sync <= {stb_sync[0], panel_stb};
            oe_sync  <= {oe_sync[0], panel_oe};
            clk_d    <= clk_sync[1];
            stb_d    <= stb_sync[1];
            addr_s1  <= panel_addr;
            addr_s2  <= addr_s1;
            rgb_s1   <= panel_rgb;
            rgb_s2   <= rgb_s1;
        end
    end

    assign clk_rise  = clk_sync[1] & ~clk_d;
    assign stb_rise  = stb_sync[1] & ~stb_d;
    assign fill_full = col_cnt[CW];

    // A clock edge coinciding with the strobe is folded in before the strobe is judged.
    always_comb begin
        col_next     = col_cnt;
        overrun_next = overrun;
        if (clk_rise) begin
            if (fill_full) overrun_next = 1'b1;
            else           col_next     = col_cnt + (CW+1)'(1);
        end
    end

    assign line_ok    = (col_next == (CW+1)'(WIDTH)) && !overrun_next;
    assign drain_free = (state == IDLE) || (out_valid && out_ready && out_last);
    assign commit     = stb_rise && line_ok && drain_free;
    assign col_inc    = out_col + CW'(1);

    always_comb begin
        plane_next = '0;
        if (addr_s2 == prev_row)
            plane_next = (plane == PW'(PLANES - 1)) ? '0 : plane + PW'(1);
    end

    always_ff @(posedge display_clock) begin
        if (clk_rise && !fill_full)
            line_mem[fill_sel][col_cnt[CW-1:0]] <= rgb_s2;
    end

    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn) begin
            col_cnt       <= '0;
            overrun       <= 1'b0;
            fill_sel      <= 1'b0;
            prev_row      <= '1;
            plane         <= '0;
            oe_cnt        <= '0;
            oe_cycles     <= '0;
            lines_dropped <= '0;
            line_errors   <= '0;
        end else begin
            if (stb_rise) begin
                col_cnt   <= '0;
                overrun   <= 1'b0;
                oe_cycles <= oe_cnt;
                oe_cnt    <= '0;
                if (!line_ok) begin
                    if (line_errors != '1) line_errors <= line_errors + CNT_BITS'(1);
                end else if (!drain_free) begin
                    if (lines_dropped != '1) lines_dropped <= lines_dropped + CNT_BITS'(1);
                end else begin
                    fill_sel <= ~fill_sel;
                    prev_row <= addr_s2;
                    plane    <= plane_next;
                end
            end else begin
                col_cnt <= col_next;
                overrun <= overrun_next;
                if (!oe_sync[1] && oe_cnt != '1) oe_cnt <= oe_cnt + 16'd1;
            end
        end
    end

    // Drain reads the buffer not being filled; the next address is read on each
    // handshake so the registered pixel is ready one cycle later without bubbles.
    always_ff @(posedge display_clock or negedge display_resetn) begin
        if (!display_resetn) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_pixel   <= '0;
            out_col     <= '0;
            out_row     <= '0;
            out_plane   <= '0;
            out_last    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (state == SEND && out_ready) begin
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_col   <= col_inc;
                    out_pixel <= line_mem[~fill_sel][col_inc];
                    out_last  <= (col_inc == CW'(WIDTH - 1));
                end
            end
            if (commit) begin
                state       <= SEND;
                out_valid   <= 1'b1;
                out_col     <= '0;
                out_pixel   <= line_mem[fill_sel][0];
                out_row     <= addr_s2;
                out_plane   <= plane_next;
                out_last    <= (WIDTH == 1);
                frame_start <= (addr_s2 == '0) && (plane_next == '0);
            end
        end
    end
endmodule
